// File: rtl/brc_pkg.sv
// Shared types and helpers for the iterative branch comparator.
// Funct3 decode lives here so the datapath stays small.
package brc_pkg;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } brc_state_e;

  // funct3[1] selects unsigned; 010/011 land here too
  function automatic logic is_unsigned(input logic [2:0] f3);
    return f3[1];
  endfunction

  // only 010 and 011 are not branch encodings
  function automatic logic br_legal(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

  // funct3[2] picks less vs equal, funct3[0] inverts
  function automatic logic br_decide(
    input logic [2:0] f3,
    input logic       lt,
    input logic       eq
  );
    if (!br_legal(f3))
      return 1'b0;
    if (!f3[2])
      return eq ^ f3[0];
    return lt ^ f3[0];
  endfunction

endpackage

// File: rtl/brc_iter_if.sv
// Request/response bundle between operand read and branch resolve.
// Names follow the comparator's port list.
interface brc_iter_if #(
  parameter int XLEN = 32
);
  logic            i_flush;
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [2:0]      i_funct3;
  logic            o_valid;
  logic            i_ready;
  logic            o_br_less;
  logic            o_br_equal;
  logic            o_br_taken;
  logic            o_illegal;

  modport master (
    output i_flush, i_valid,
    output i_rs1_data, i_rs2_data,
    output i_funct3, i_ready,
    input  o_ready, o_valid,
    input  o_br_less, o_br_equal,
    input  o_br_taken, o_illegal
  );

  modport slave (
    input  i_flush, i_valid,
    input  i_rs1_data, i_rs2_data,
    input  i_funct3, i_ready,
    output o_ready, o_valid,
    output o_br_less, o_br_equal,
    output o_br_taken, o_illegal
  );
endinterface

// File: rtl/brc_chunk_cmp.sv
// Unsigned compare of one operand chunk.
// Purely combinational; the top feeds it the active chunk.
module brc_chunk_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt,
  output logic         eq
);

  // magnitude and equality of the selected slice
  always_comb begin
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/brc_iter.sv
// Multi-cycle RV32 branch comparator, MSB-first chunk scan.
// Stops on the first differing chunk; result held until taken.
module brc_iter
  import brc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input logic       i_clk,
  input logic       i_rst_n,
  brc_iter_if.slave bus
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IW =
    (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((XLEN % CHUNK) != 0) begin : g_bad
    $error("brc_iter: CHUNK must divide XLEN");
  end

  brc_state_e      state_q;
  brc_state_e      state_d;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [2:0]      f3_q;
  logic [IW-1:0]   idx_q;
  logic            less_q;
  logic            equal_q;
  logic            taken_q;
  logic            ill_q;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic             ch_lt;
  logic             ch_eq;
  logic             accept;
  logic             last;
  logic [XLEN-1:0]  msb_flip;

  assign a_ch = a_q[idx_q*CHUNK +: CHUNK];
  assign b_ch = b_q[idx_q*CHUNK +: CHUNK];

  brc_chunk_cmp #(
    .W (CHUNK)
  ) u_cmp (
    .a  (a_ch),
    .b  (b_ch),
    .lt (ch_lt),
    .eq (ch_eq)
  );

  // handshake and scan-terminate qualifiers
  always_comb begin
    accept = (state_q == IDLE)
           & bus.i_valid & ~bus.i_flush;
    last   = (idx_q == '0);
    msb_flip = '0;
    msb_flip[XLEN-1] =
      ~is_unsigned(bus.i_funct3);
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // next state; flush wins over everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (!ch_eq || last) state_d = DONE;
      DONE: if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.i_flush)
      state_d = IDLE;
  end

  // handshake and result outputs
  always_comb begin
    bus.o_ready    = (state_q == IDLE);
    bus.o_valid    = (state_q == DONE);
    bus.o_br_less  = less_q;
    bus.o_br_equal = equal_q;
    bus.o_br_taken = taken_q;
    bus.o_illegal  = ill_q;
  end

  // operand capture, chunk walk and result latch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      idx_q   <= '0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.i_rs1_data ^ msb_flip;
      b_q   <= bus.i_rs2_data ^ msb_flip;
      f3_q  <= bus.i_funct3;
      idx_q <= IW'(NCHUNK - 1);
    end else if (state_q == SCAN && !bus.i_flush) begin
      if (!ch_eq) begin
        less_q  <= ch_lt;
        equal_q <= 1'b0;
        taken_q <= br_decide(f3_q, ch_lt, 1'b0);
        ill_q   <= ~br_legal(f3_q);
      end else if (last) begin
        less_q  <= 1'b0;
        equal_q <= 1'b1;
        taken_q <= br_decide(f3_q, 1'b0, 1'b1);
        ill_q   <= ~br_legal(f3_q);
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

endmodule
